// File: rtl/mux_sync_tx.sv
// mux_sync_tx: source-domain launch controller for the mux_synchronizer path.
// Accepts one word on a valid/ready stream, holds it on data_o and raises a
// four-phase request level (en_o). The destination acknowledge is brought in
// through a local synchronizer chain and closes the handshake.
// Optional feature: define MUX_SYNC_TX_TIMEOUT_EN to bound the time spent
// waiting for the acknowledge (TIMEOUT_CYCLES), reported on timeout_o.
module mux_sync_tx #(
   parameter int CHAIN_LENGTH   = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  en_o,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  ack_i,
   output logic                  busy_o,
   output logic                  timeout_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_REL  = 2'd2
   } state_t;

   // Reject illegal parameterizations at elaboration time.
   if (CHAIN_LENGTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("mux_sync_tx: CHAIN_LENGTH must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [CHAIN_LENGTH-1:0] r_ack_sync;
   logic                    w_ack_s;
   logic                    w_accept;
   logic                    w_timeout_hit;

   // Acknowledge synchronizer; only the last stage is ever used for decisions.
   always_ff @(posedge clk_i) begin
      if (reset_i) r_ack_sync <= '0;
      else         r_ack_sync <= {r_ack_sync[CHAIN_LENGTH-2:0], ack_i};
   end

   assign w_ack_s = r_ack_sync[CHAIN_LENGTH-1];

   // A stale high ack in IDLE blocks acceptance so the next request cannot
   // be mistaken as already acknowledged.
   assign ready_o  = !reset_i && (r_state == S_IDLE) && !w_ack_s;
   assign w_accept = valid_i && ready_o;

`ifdef MUX_SYNC_TX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_to_cnt;
   logic          r_timeout;

   // Limit is reached on the edge where the count would become TIMEOUT_CYCLES;
   // an ack seen in the same cycle takes priority.
   assign w_timeout_hit = (r_state == S_REQ) && !w_ack_s &&
                          (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Count REQ cycles without ack; restarts on every accept.
   always_ff @(posedge clk_i) begin
      if (reset_i)                         r_to_cnt <= '0;
      else if (w_accept)                   r_to_cnt <= '0;
      else if (r_state == S_REQ && !w_ack_s) r_to_cnt <= r_to_cnt + 1'b1;
   end

   // One-cycle timeout pulse.
   always_ff @(posedge clk_i) begin
      if (reset_i) r_timeout <= 1'b0;
      else         r_timeout <= w_timeout_hit;
   end

   assign timeout_o = r_timeout;
`else
   assign w_timeout_hit = 1'b0;
   assign timeout_o     = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic for the four-phase handshake.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)           w_state_nxt = S_REQ;
         S_REQ:   if (w_ack_s)            w_state_nxt = S_REL;
                  else if (w_timeout_hit) w_state_nxt = S_REL;
         S_REL:   if (!w_ack_s)           w_state_nxt = S_IDLE;
         default:                         w_state_nxt = S_IDLE;
      endcase
   end

   // Registered outputs follow the next state so they line up with r_state.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         en_o   <= 1'b0;
         busy_o <= 1'b0;
      end else begin
         en_o   <= (w_state_nxt == S_REQ);
         busy_o <= (w_state_nxt != S_IDLE);
      end
   end

   // Payload is captured only on accept and held until the next one.
   always_ff @(posedge clk_i) begin
      if (reset_i)       data_o <= '0;
      else if (w_accept) data_o <= data_i;
   end

endmodule

// File: tb/tb_mux_sync_tx.sv
// Bench for mux_sync_tx: directed scenarios plus random traffic, checked
// against a timing model derived from the loopback handshake arithmetic.
module tb_mux_sync_tx;
   localparam int CL = 2;
   localparam int DW = 32;
`ifdef MUX_SYNC_TX_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 256;
`endif

   logic          clk;
   logic          reset_i;
   logic          valid_i;
   logic          ready_o;
   logic [DW-1:0] data_i;
   logic          en_o;
   logic [DW-1:0] data_o;
   logic          ack_i;
   logic          busy_o;
   logic          timeout_o;

   logic loop;
   logic ack_drv;

   assign ack_i = loop ? en_o : ack_drv;

   mux_sync_tx #(
      .CHAIN_LENGTH  (CL),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i    (clk),
      .reset_i  (reset_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data_i   (data_i),
      .en_o     (en_o),
      .data_o   (data_o),
      .ack_i    (ack_i),
      .busy_o   (busy_o),
      .timeout_o(timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests   = 0;
   int          n_fail    = 0;
   int          edge_n    = 0;
   int          acc_e     = -1000;
   int          rdy_from  = 0;
   int          rise_e    = -1;
   logic [31:0] exp_data  = '0;
   bit          model_on  = 1'b1;
   logic        prev_en   = 1'b0;
   logic [31:0] prev_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check ready before the edge, update the model
   // at the edge, check registered outputs just after it.
   task automatic step(input logic v, input logic [31:0] d, input logic rst);
      logic exp_rdy;
      valid_i = v;
      data_i  = d;
      reset_i = rst;
      #1;
      exp_rdy = !rst && (edge_n + 1 >= rdy_from);
      if (model_on) chk("ready_o", {31'b0, ready_o}, {31'b0, exp_rdy});
      @(posedge clk);
      edge_n++;
      if (model_on) begin
         if (rst) begin
            acc_e    = -1000;
            exp_data = '0;
            rdy_from = edge_n + 1;
         end else if (v && exp_rdy) begin
            acc_e    = edge_n;
            exp_data = d;
            rdy_from = edge_n + 2*CL + 3;
         end
      end
      #1;
      if (model_on) begin
         chk("en_o", {31'b0, en_o}, {31'b0, (edge_n >= acc_e && edge_n <= acc_e + CL)});
         chk("data_o", data_o, exp_data);
         chk("busy_o", {31'b0, busy_o}, {31'b0, (edge_n >= acc_e && edge_n <= acc_e + 2*CL + 1)});
         chk("timeout_o", {31'b0, timeout_o}, 32'd0);
      end
      if (prev_en && en_o) chk("data_hold", data_o, prev_data);
      if (!prev_en && en_o) rise_e = edge_n;
      prev_en   = en_o;
      prev_data = data_o;
   endtask

   initial begin
      int e1;
      reset_i = 1'b1;
      valid_i = 1'b0;
      data_i  = '0;
      loop    = 1'b1;
      ack_drv = 1'b0;

      // Reset state.
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);

      // Single loopback transfer.
      step(1'b1, 32'hc0debeef, 1'b0);
      repeat (2*CL + 4) step(1'b0, $urandom, 1'b0);

      // Back-to-back with valid held high.
      step(1'b1, 32'hc0debeef, 1'b0);
      e1 = rise_e;
      repeat (2*CL + 3) step(1'b1, 32'h00c0ffee, 1'b0);
      chk("b2b_spacing", rise_e - e1, 2*CL + 3);

      // data_i changes while the request is outstanding.
      repeat (2*CL + 2) step(1'b1, 32'hdeadbeef, 1'b0);
      chk("data_in_req", data_o, 32'h00c0ffee);
      step(1'b0, 32'h0, 1'b0);

      // Reset during REQ, then a normal transfer.
      step(1'b1, 32'h12345678, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b1);
      chk("rst_mid_en", {31'b0, en_o}, 32'd0);
      chk("rst_mid_data", data_o, 32'd0);
      step(1'b1, 32'h5a5a5a5a, 1'b0);
      repeat (2*CL + 3) step(1'b0, 32'h0, 1'b0);
      chk("after_rst_data", data_o, 32'h5a5a5a5a);

      // Stale ack held across reset release blocks acceptance.
      loop    = 1'b0;
      ack_drv = 1'b1;
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      repeat (CL) step(1'b0, 32'h0, 1'b0);
      rdy_from = 1 << 30;
      repeat (4) step(1'b1, 32'hbad0bad0, 1'b0);
      loop     = 1'b1;
      e1       = edge_n;
      rdy_from = edge_n + CL + 1;
      repeat (CL + 1) step(1'b1, 32'h0123abcd, 1'b0);
      chk("stale_accept_delay", rise_e - e1, CL + 1);
      repeat (2*CL + 3) step(1'b0, 32'h0, 1'b0);

`ifdef MUX_SYNC_TX_TIMEOUT_EN
      // No acknowledge at all: request times out after TO REQ cycles.
      loop    = 1'b0;
      ack_drv = 1'b0;
      step(1'b1, 32'hfeedf00d, 1'b0);
      model_on = 1'b0;
      repeat (TO - 1) begin
         step(1'b0, 32'h0, 1'b0);
         chk("to_en_wait", {31'b0, en_o}, 32'd1);
         chk("to_quiet", {31'b0, timeout_o}, 32'd0);
      end
      step(1'b0, 32'h0, 1'b0);
      chk("to_pulse", {31'b0, timeout_o}, 32'd1);
      chk("to_en_fall", {31'b0, en_o}, 32'd0);
      step(1'b0, 32'h0, 1'b0);
      chk("to_pulse_end", {31'b0, timeout_o}, 32'd0);
      chk("to_ready", {31'b0, ready_o}, 32'd1);
      model_on = 1'b1;
      acc_e    = -1000;
      rdy_from = edge_n + 1;
      loop     = 1'b1;
`endif

      // Random traffic with occasional resets.
      repeat (120) step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 24) == 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mux_sync_tx.md
# mux_sync_tx

Source-domain launch controller for the `mux_synchronizer` CDC path. It accepts words on a valid/ready stream in the source clock domain and registers them onto a held data bus. It drives a four-phase level enable toward the destination `mux_synchronizer` and waits for the destination's acknowledge, resynchronized locally, before accepting the next word. It sits directly upstream of `mux_synchronizer`: `en_o`/`data_o` connect to its `en_i`/`data_i`.

## Interface
- `CHAIN_LENGTH`, 2: ack synchronizer flop count; must be ≥ 2.
- `DATA_WIDTH`, 32: payload width.
- `TIMEOUT_CYCLES`, 256: maximum cycles spent in REQ; used only with `MUX_SYNC_TX_TIMEOUT_EN`; must be ≥ 1.
- `clk_i`  in  1  source-domain clock; the only clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  upstream word valid.
- `ready_o`  out  1  block can accept a word this cycle.
- `data_i`  in  DATA_WIDTH  upstream word.
- `en_o`  out  1  registered four-phase request level to the destination.
- `data_o`  out  DATA_WIDTH  registered held payload to the destination.
- `ack_i`  in  1  asynchronous acknowledge level from the destination domain.
- `busy_o`  out  1  transfer in progress (state ≠ IDLE).
- `timeout_o`  out  1  one-cycle pulse on request timeout; constant 0 when the feature is compiled out.

## Operation
- `ack_i` passes through a `CHAIN_LENGTH`-flop synchronizer; `ack_s` is the last stage. All decisions use `ack_s` only.
- FSM states:
  - IDLE
    - `ready_o = !ack_s`.
    - On `valid_i && ready_o`: `data_o <= data_i`, `en_o <= 1`, go to REQ.
  - REQ
    - `en_o` stays 1.
    - On `ack_s == 1`: `en_o <= 0`, go to REL.
  - REL
    - `en_o` stays 0.
    - On `ack_s == 0`: go to IDLE.
- `data_o` changes only on an accept edge. It is held stable from accept until the next accept, including across REQ and REL.
- `ready_o` is combinational from state and `ack_s`, and is forced to 0 while `reset_i` is high.
- A stale high `ack_s` in IDLE blocks acceptance until it falls. This prevents a false completion.
- `valid_i` and `data_i` are ignored whenever `ready_o` is 0. No buffering.
- `busy_o` is registered from the state: high in REQ and REL.

## Timing
- Reset values:
  - `en_o=0`, `data_o=0`, `busy_o=0`, `timeout_o=0`.
  - All synchronizer flops 0; state IDLE; timeout counter 0.
  - `ready_o` is 1 in the first cycle after reset deasserts.
- Accept at edge 0: `en_o` and `data_o` are valid after edge 0.
- Loopback (`ack_i` tied to `en_o`), CL = `CHAIN_LENGTH`:
  - `ack_s` rises after edge CL; REQ→REL at edge CL+1, and `en_o` falls after it.
  - `ack_s` falls after edge 2CL+1; REL→IDLE at edge 2CL+2.
  - The earliest next accept is edge 2CL+3, so the minimum accept-to-accept spacing is 2·CL+3 cycles (7 for CL = 2).
- Reset asserted mid-transfer: at the next edge, `en_o` and `data_o` clear, the state goes to IDLE, and the synchronizer clears. The destination observes `en` falling as a release.

## Configuration
- `MUX_SYNC_TX_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to REQ and increments each REQ cycle with `ack_s == 0`.
  - When it reaches `TIMEOUT_CYCLES`, on that edge: `en_o <= 0`, `timeout_o <= 1` for one cycle, go to REL.
  - If `ack_s` rises on the same edge the count hits the limit, ack wins and no timeout is signalled.
- Not defined: no counter; REQ waits indefinitely; `timeout_o` is tied to 0.

## Test plan
- Reset, then a loopback accept of `32'hc0debeef` at edge 0:
  - `en_o` is high for edges 1..CL+1.
  - `data_o = 32'hc0debeef` throughout.
  - `busy_o` drops after return to IDLE.
  - `ready_o` is high again by edge 2CL+3.
- Back-to-back `32'hc0debeef` then `32'h00c0ffee` with `valid_i` held high, loopback:
  - Second accept occurs exactly 2CL+3 cycles after the first.
  - `data_o` never changes while `en_o` is high.
- Hold `ack_i = 1` through reset release:
  - `ready_o` stays 0 and no accept occurs.
  - Drop `ack_i`: accept occurs CL+1 cycles later.
- Change `data_i` from `32'h00c0ffee` to `32'hdeadbeef` during REQ: `data_o` stays `32'h00c0ffee`.
- Assert `reset_i` for one cycle in REQ: after the edge, `en_o=0`, `data_o=0`, state IDLE; the next transfer completes normally.
- With `MUX_SYNC_TX_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`, `ack_i` held at 0:
  - Accept, then `timeout_o` pulses once, 8 REQ cycles later.
  - `en_o` falls on the same edge.
  - `ready_o` returns one cycle after that.
